// File: rtl/button_debounce_pkg.sv
// Shared constants and helpers for the push-button debouncer.
package button_pkg;
  localparam int   DEBOUNCE_CYCLES_DEFAULT = 500000;
  localparam int   DEBOUNCE_CYCLES_SIM     = 4;
  localparam logic BTN_IDLE                = 1'b1;

  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction
endpackage

// File: rtl/button_debounce_if.sv
// Button conduit: raw pins in, clean level and press/release strobes out.
interface button_debounce_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] button_raw;
  logic [WIDTH-1:0] button_clean;
  logic [WIDTH-1:0] press_pulse;
  logic [WIDTH-1:0] release_pulse;

  modport master (output button_raw, input button_clean, press_pulse, release_pulse);
  modport slave  (input button_raw, output button_clean, press_pulse, release_pulse);
endinterface

// File: rtl/button_debounce_channel.sv
// One button channel: 2-flop synchronizer, stability counter, edge strobes.
module debounce_channel
  import button_pkg::*;
#(
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic RESET_LEVEL     = BTN_IDLE
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic clean_o,
  output logic press_o,
  output logic release_o
);
  localparam int CNT_W = (clog2(DEBOUNCE_CYCLES) < 1) ? 1 : clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             stable_q, stable_d;
  logic             press_q, press_d;
  logic             release_q, release_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Terminal compare precedes the increment, so the counter never wraps.
  always_comb begin
    stable_d  = stable_q;
    cnt_d     = '0;
    press_d   = 1'b0;
    release_d = 1'b0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d  = sync2_q;
        press_d   = ~sync2_q;
        release_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q   <= RESET_LEVEL;
      sync2_q   <= RESET_LEVEL;
      stable_q  <= RESET_LEVEL;
      cnt_q     <= '0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= raw_i;
      sync2_q   <= sync1_q;
      stable_q  <= stable_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign clean_o   = stable_q;
  assign press_o   = press_q;
  assign release_o = release_q;
endmodule

// File: rtl/button_debounce.sv
// WIDTH independent debounce channels between the board pins and the button PIO.
module button_debounce
  import button_pkg::*;
#(
  parameter int   WIDTH           = 4,
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter logic RESET_LEVEL     = BTN_IDLE
) (
  input logic              clk,
  input logic              reset,
  button_debounce_if.slave btn
);
  logic [WIDTH-1:0] clean, press, rel;

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (RESET_LEVEL)
    ) u_ch (
      .clk      (clk),
      .reset    (reset),
      .raw_i    (btn.button_raw[g]),
      .clean_o  (clean[g]),
      .press_o  (press[g]),
      .release_o(rel[g])
    );
  end

  assign btn.button_clean  = clean;
  assign btn.press_pulse   = press;
  assign btn.release_pulse = rel;
endmodule

// File: tb/tb_button_debounce.sv
// Bench for button_debounce: directed scenarios plus random bouncing vs a window model.
module tb_button_debounce;
  import button_pkg::*;
  localparam int W = 4;
  localparam int N = DEBOUNCE_CYCLES_SIM;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  button_debounce_if #(.WIDTH(W)) btn();

  button_debounce #(.WIDTH(W), .DEBOUNCE_CYCLES(N), .RESET_LEVEL(1'b1)) dut (
    .clk  (clk),
    .reset(reset),
    .btn  (btn)
  );

  always #5 clk = ~clk;

  // Model: a channel flips once the raw samples seen by the synchronizer output
  // have all differed from the clean level for N consecutive edges.
  logic [W-1:0] hist [0:N];
  logic [W-1:0] m_clean, m_press, m_rel;

  function automatic logic [W-1:0] accept_mask(input logic [W-1:0] c);
    logic [W-1:0] m;
    m = '1;
    for (int i = 0; i < W; i++)
      for (int k = 1; k <= N; k++)
        if (hist[k][i] == c[i]) m[i] = 1'b0;
    return m;
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int k = 0; k <= N; k++) hist[k] <= '1;
      m_clean <= '1;
      m_press <= '0;
      m_rel   <= '0;
    end else begin
      hist[0] <= btn.button_raw;
      for (int k = 1; k <= N; k++) hist[k] <= hist[k-1];
      m_clean <= m_clean ^ accept_mask(m_clean);
      m_press <= accept_mask(m_clean) & m_clean;
      m_rel   <= accept_mask(m_clean) & ~m_clean;
    end
  end

  task automatic settle(input logic [W-1:0] v);
    btn.button_raw = v;
    repeat (N + 4) @(negedge clk);
  endtask

  task automatic test_reset;
    btn.button_raw = '1;
    reset = 1'b1;
    repeat (2) begin
      @(negedge clk);
      n_checks++;
      if ({btn.button_clean, btn.press_pulse, btn.release_pulse} !== {4'hF, 4'h0, 4'h0})
        $display("FAIL reset_values got clean=%b press=%b rel=%b want 1111/0000/0000",
                 btn.button_clean, btn.press_pulse, btn.release_pulse);
      else n_pass++;
    end
    reset = 1'b0;
    for (int e = 1; e <= N + 4; e++) begin
      @(negedge clk);
      n_checks++;
      if ({btn.button_clean, btn.press_pulse, btn.release_pulse} !== {4'hF, 4'h0, 4'h0})
        $display("FAIL reset_release e=%0d got clean=%b press=%b rel=%b want 1111/0000/0000",
                 e, btn.button_clean, btn.press_pulse, btn.release_pulse);
      else n_pass++;
    end
  endtask

  // pre_edges > 0 starts a press that far ahead of the reset pulse.
  task automatic test_reset_hold(input string name, input int pre_edges);
    if (pre_edges > 0) begin
      settle('1);
      btn.button_raw = '0;
      repeat (pre_edges) @(negedge clk);
    end
    btn.button_raw = '0;
    reset = 1'b1;
    #1;
    n_checks++;
    if ({btn.button_clean, btn.press_pulse, btn.release_pulse} !== {4'hF, 4'h0, 4'h0})
      $display("FAIL %s async got clean=%b press=%b rel=%b want 1111/0000/0000",
               name, btn.button_clean, btn.press_pulse, btn.release_pulse);
    else n_pass++;
    repeat (3) begin
      @(negedge clk);
      n_checks++;
      if ({btn.button_clean, btn.press_pulse, btn.release_pulse} !== {4'hF, 4'h0, 4'h0})
        $display("FAIL %s in_reset got clean=%b press=%b rel=%b want 1111/0000/0000",
                 name, btn.button_clean, btn.press_pulse, btn.release_pulse);
      else n_pass++;
    end
    reset = 1'b0;
    for (int e = 1; e <= N + 4; e++) begin
      logic [W-1:0] xc, xp;
      @(negedge clk);
      xc = (e >= N + 2) ? 4'h0 : 4'hF;
      xp = (e == N + 2) ? 4'hF : 4'h0;
      n_checks++;
      if ({btn.button_clean, btn.press_pulse, btn.release_pulse} !== {xc, xp, 4'h0})
        $display("FAIL %s e=%0d got clean=%b press=%b rel=%b want %b/%b/0000",
                 name, e, btn.button_clean, btn.press_pulse, btn.release_pulse, xc, xp);
      else n_pass++;
    end
  endtask

  task automatic test_clean_press;
    settle('1);
    for (int phase = 0; phase < 2; phase++) begin
      btn.button_raw[0] = (phase == 1);
      for (int e = 0; e < 20; e++) begin
        logic [2:0] x;
        @(negedge clk);
        if (phase == 0) x = {(e >= N + 1) ? 1'b0 : 1'b1, e == N + 1, 1'b0};
        else            x = {(e >= N + 1) ? 1'b1 : 1'b0, 1'b0, e == N + 1};
        n_checks++;
        if ({btn.button_clean[0], btn.press_pulse[0], btn.release_pulse[0]} !== x)
          $display("FAIL clean_press ph=%0d e=%0d got c/p/r=%b want %b", phase, e,
                   {btn.button_clean[0], btn.press_pulse[0], btn.release_pulse[0]}, x);
        else n_pass++;
      end
    end
  endtask

  task automatic test_bounce;
    logic [8:0] pat;
    int         npress;
    pat    = 9'b011001100;
    npress = 0;
    settle('1);
    for (int j = 0; j < 20; j++) begin
      logic [2:0] x;
      if (j <= 8) btn.button_raw[1] = pat[j];
      @(negedge clk);
      if (btn.press_pulse[1]) npress++;
      x = {(j >= 8 + N + 1) ? 1'b0 : 1'b1, j == 8 + N + 1, 1'b0};
      n_checks++;
      if ({btn.button_clean[1], btn.press_pulse[1], btn.release_pulse[1]} !== x)
        $display("FAIL bounce j=%0d got c/p/r=%b want %b", j,
                 {btn.button_clean[1], btn.press_pulse[1], btn.release_pulse[1]}, x);
      else n_pass++;
    end
    n_checks++;
    if (npress !== 1) $display("FAIL bounce_press_count got %0d want 1", npress);
    else n_pass++;
  endtask

  task automatic test_glitch;
    settle('1);
    for (int j = 0; j < 13; j++) begin
      btn.button_raw[2] = (j >= 3);
      @(negedge clk);
      n_checks++;
      if ({btn.button_clean[2], btn.press_pulse[2], btn.release_pulse[2]} !== 3'b100)
        $display("FAIL glitch_short j=%0d got c/p/r=%b want 100", j,
                 {btn.button_clean[2], btn.press_pulse[2], btn.release_pulse[2]});
      else n_pass++;
    end
    settle('1);
    for (int j = 0; j < 15; j++) begin
      logic [2:0] x;
      btn.button_raw[2] = (j >= 5);
      @(negedge clk);
      x = {(j >= 5 && j < 10) ? 1'b0 : 1'b1, j == 5, j == 10};
      n_checks++;
      if ({btn.button_clean[2], btn.press_pulse[2], btn.release_pulse[2]} !== x)
        $display("FAIL glitch_long j=%0d got c/p/r=%b want %b", j,
                 {btn.button_clean[2], btn.press_pulse[2], btn.release_pulse[2]}, x);
      else n_pass++;
    end
  endtask

  task automatic test_simultaneous;
    settle('1);
    btn.button_raw = 4'b0110;
    for (int e = 0; e < 8; e++) begin
      logic [W-1:0] xc, xp;
      @(negedge clk);
      xc = (e >= N + 1) ? 4'b0110 : 4'b1111;
      xp = (e == N + 1) ? 4'b1001 : 4'b0000;
      n_checks++;
      if ({btn.button_clean, btn.press_pulse, btn.release_pulse} !== {xc, xp, 4'h0})
        $display("FAIL simultaneous e=%0d got clean=%b press=%b rel=%b want %b/%b/0000",
                 e, btn.button_clean, btn.press_pulse, btn.release_pulse, xc, xp);
      else n_pass++;
    end
  endtask

  task automatic test_random;
    int dwell [W];
    for (int i = 0; i < W; i++) dwell[i] = 0;
    for (int c = 0; c < 800; c++) begin
      for (int i = 0; i < W; i++) begin
        if (dwell[i] == 0) begin
          btn.button_raw[i] = 1'($urandom_range(0, 1));
          dwell[i] = $urandom_range(1, 2 * N);
        end
        dwell[i]--;
      end
      @(negedge clk);
      n_checks++;
      if (btn.button_clean !== m_clean)
        $display("FAIL rand_clean c=%0d got %b want %b", c, btn.button_clean, m_clean);
      else n_pass++;
      n_checks++;
      if (btn.press_pulse !== m_press)
        $display("FAIL rand_press c=%0d got %b want %b", c, btn.press_pulse, m_press);
      else n_pass++;
      n_checks++;
      if (btn.release_pulse !== m_rel)
        $display("FAIL rand_release c=%0d got %b want %b", c, btn.release_pulse, m_rel);
      else n_pass++;
      n_checks++;
      if ((btn.press_pulse & btn.release_pulse) !== 4'h0)
        $display("FAIL rand_exclusive c=%0d got %b want 0000", c,
                 btn.press_pulse & btn.release_pulse);
      else n_pass++;
    end
  endtask

  initial begin
    btn.button_raw = '1;
    @(negedge clk);
    test_reset();
    test_clean_press();
    test_bounce();
    test_glitch();
    test_simultaneous();
    test_reset_hold("reset_low", 0);
    test_reset_hold("reset_midcount", 4);
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/button_debounce.md
Name: button_debounce

Overview:
- Upstream conditioning stage for the button PIO: takes raw, asynchronous, bouncing push-button levels from the board pins and feeds a clean, synchronous level into the PIO's `in_port`.
- The PIO's falling-edge capture and IRQ logic then see exactly one edge per physical press.
- Also provides one-cycle press/release strobes for hardware consumers that bypass the CPU.
- Sits between the top-level pin ports and the Qsys system's `button_pio` input conduit.

Parameters:
- WIDTH, 4, number of independent button channels.
- DEBOUNCE_CYCLES, 500000, consecutive stable clk cycles required to accept a new level (10 ms at 50 MHz); legal range 2 to 2^24.
- RESET_LEVEL, 1, idle/reset level of every channel (buttons are active-low, so idle is 1).

Ports:
- clk  input  1  system clock, all logic on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- button_raw  input  WIDTH  raw pin levels, asynchronous to clk.
- button_clean  output  WIDTH  debounced level, drives PIO `in_port`.
- press_pulse  output  WIDTH  one-cycle strobe per channel on an accepted 1->0 transition.
- release_pulse  output  WIDTH  one-cycle strobe per channel on an accepted 0->1 transition.

Behaviour:
- One clock; reset is asynchronous and active-high (ports named `clk` and `reset`).
- Reset values (asynchronous on `reset` assertion):
  - sync flops and `button_clean` all = RESET_LEVEL.
  - counters = 0.
  - `press_pulse` = 0 and `release_pulse` = 0.
  - No pulse is generated on reset release.
- Synchronizer: per channel, 2-flop synchronizer `sync1` -> `sync2`. Only `sync2` is used downstream. No combinational path from `button_raw` to any output.
- Per-channel counter:
  - Width is CNT_W = clog2(DEBOUNCE_CYCLES).
  - If `sync2` == stable: counter <= 0.
  - If `sync2` != stable and counter < DEBOUNCE_CYCLES-1: counter <= counter+1.
  - If `sync2` != stable and counter == DEBOUNCE_CYCLES-1: stable <= `sync2` and counter <= 0.
  - The counter never wraps; the terminal compare happens before any increment.
- Latency: a clean step on `button_raw` that settles before clk edge k appears on `button_clean` after edge k+1+DEBOUNCE_CYCLES.
- Glitch rejection: any return of `sync2` to the stable value before DEBOUNCE_CYCLES consecutive mismatches clears the counter. The output does not change, and the next mismatch restarts counting from 0.
- Pulses:
  - Registered, asserted in exactly the cycle `button_clean` first shows the new value, for one cycle, then 0.
  - `press_pulse[i]` fires on stable 1->0; `release_pulse[i]` fires on stable 0->1.
  - `press_pulse[i]` and `release_pulse[i]` are never asserted together.
- Channels are fully independent. Simultaneous transitions on several channels produce simultaneous pulses with no arbitration.
- Reset mid-count: the count is discarded and the channel returns to RESET_LEVEL. A button held low through reset release is accepted DEBOUNCE_CYCLES+2 cycles later and yields one `press_pulse`.
- No CPU-visible registers; the block is always enabled.

Decomposition:
- Shared package `button_pkg` holds:
  - `DEBOUNCE_CYCLES_DEFAULT` (500000).
  - `DEBOUNCE_CYCLES_SIM` (4).
  - a `clog2` constant function.
  - `BTN_IDLE` (1'b1).
- Sub-module `debounce_channel`: a single-bit synchronizer, counter and pulse logic.
- `button_debounce` instantiates WIDTH copies in a generate loop and concatenates the outputs.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=4, RESET_LEVEL=1):
- Reset asserted mid-simulation with raw=4'b0000 -> `button_clean`=4'b1111, all pulses 0 during reset. After release, `button_clean`=4'b0000 exactly 6 edges later, with `press_pulse`=4'b1111 for that single cycle.
- Clean press: raw[0] 1->0 before edge 10 -> `button_clean[0]`=0 after edge 15, `press_pulse[0]`=1 only in that cycle. Release 20 cycles later -> symmetric `release_pulse[0]`.
- Bounce: raw[1] toggles 0,1,0,1,0 with 2-cycle dwell, then holds 0 -> exactly one `press_pulse[1]`, 4+2 cycles after the final settle. `button_clean[1]` never toggles during the bounce.
- Glitch: raw[2] low for 3 cycles then high -> `button_clean[2]` stays 1 and no pulse occurs. Low for 5 cycles -> accepted.
- Simultaneous: raw[3] and raw[0] pressed on the same edge -> `press_pulse`=4'b1001 in the same cycle.
- Reset asserted 2 counts into a pending press with raw held low -> no early transition; accepted 6 cycles after reset release.
